// File: rtl/ea_unit.sv
// ea_unit: SLC-3 effective-address unit; decodes the latched IR, forms the EA and
// performs the LDI/STI/TRAP indirect read over a req/ack handshake.
`default_nettype none

module ea_unit #(
  parameter int ACK_TIMEOUT = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        start,
  input  logic [15:0] ir,
  input  logic [15:0] pc,
  input  logic [15:0] base_r,
  input  logic [15:0] sext6,
  input  logic [15:0] sext9,
  input  logic [15:0] sext11,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_rdata,
  output logic [15:0] ea,
  output logic        no_ea,
  output logic        err,
  output logic        busy,
  output logic        done
);

  // Wait counter counts IND cycles 0..ACK_TIMEOUT-1; the last value is the final request cycle.
  localparam int              CW      = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CW-1:0]   LAST    = (ACK_TIMEOUT > 0) ? CW'(ACK_TIMEOUT - 1) : '0;
  localparam bit              TO_EN   = (ACK_TIMEOUT != 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    IND  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;

  logic [15:0]   ir_lat;
  logic [15:0]   pc_lat;
  logic [15:0]   base_lat;
  logic [15:0]   s6_lat;
  logic [15:0]   s9_lat;
  logic [15:0]   s11_lat;
  logic [CW-1:0] wait_cnt;

  logic [15:0]   ea_next;
  logic          no_ea_next;
  logic          err_next;
  logic [CW-1:0] wait_cnt_next;
  logic          accept;

  logic          unused_ir;
  assign unused_ir = ^ir_lat[10:8];

  assign accept = (state == IDLE) && start;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ea       <= '0;
      no_ea    <= 1'b0;
      err      <= 1'b0;
      wait_cnt <= '0;
      ir_lat   <= '0;
      pc_lat   <= '0;
      base_lat <= '0;
      s6_lat   <= '0;
      s9_lat   <= '0;
      s11_lat  <= '0;
    end else begin
      ea       <= ea_next;
      no_ea    <= no_ea_next;
      err      <= err_next;
      wait_cnt <= wait_cnt_next;
      if (accept) begin
        ir_lat   <= ir;
        pc_lat   <= pc;
        base_lat <= base_r;
        s6_lat   <= sext6;
        s9_lat   <= sext9;
        s11_lat  <= sext11;
      end
    end
  end

  always_comb begin
    state_next    = state;
    ea_next       = ea;
    no_ea_next    = no_ea;
    err_next      = err;
    wait_cnt_next = wait_cnt;
    mem_req       = 1'b0;
    mem_addr      = '0;
    busy          = (state != IDLE);
    done          = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ea_next    = '0;
          no_ea_next = 1'b0;
          err_next   = 1'b0;
          state_next = CALC;
        end
      end

      CALC: begin
        wait_cnt_next = '0;
        state_next    = DONE;
        case (ir_lat[15:12])
          4'b0000, 4'b0010, 4'b0011, 4'b1110: ea_next = pc_lat + s9_lat;
          4'b1010, 4'b1011: begin
            ea_next    = pc_lat + s9_lat;
            state_next = IND;
          end
          4'b0100:          ea_next = ir_lat[11] ? (pc_lat + s11_lat) : base_lat;
          4'b1100:          ea_next = base_lat;
          4'b0110, 4'b0111: ea_next = base_lat + s6_lat;
          4'b1111: begin
            // Trap vectors are zero-extended, unlike every other offset.
            ea_next    = {8'h00, ir_lat[7:0]};
            state_next = IND;
          end
          default: begin
            ea_next    = '0;
            no_ea_next = 1'b1;
          end
        endcase
      end

      IND: begin
        mem_req  = 1'b1;
        mem_addr = ea;
        if (mem_ack) begin
          ea_next    = mem_rdata;
          state_next = DONE;
        end else if (TO_EN && (wait_cnt == LAST)) begin
          ea_next    = '0;
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          wait_cnt_next = wait_cnt + CW'(1);
        end
      end

      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ea_unit.sv
// Scoreboard bench for ea_unit: stimulus pushes reference-model results, a monitor
// checks each done pulse, and a memory responder answers indirect reads.
`default_nettype none

module tb_ea_unit;

  localparam int ACK_TO = 16;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ir = '0;
  logic [15:0] pc = '0;
  logic [15:0] base_r = '0;
  logic [15:0] sext6;
  logic [15:0] sext9;
  logic [15:0] sext11;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] ea;
  logic        no_ea;
  logic        err;
  logic        busy;
  logic        done;

  assign sext6  = {{10{ir[5]}}, ir[5:0]};
  assign sext9  = {{7{ir[8]}},  ir[8:0]};
  assign sext11 = {{5{ir[10]}}, ir[10:0]};

  ea_unit #(.ACK_TIMEOUT(ACK_TO)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .ir(ir), .pc(pc), .base_r(base_r),
    .sext6(sext6), .sext9(sext9), .sext11(sext11),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ea(ea), .no_ea(no_ea), .err(err), .busy(busy), .done(done)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  typedef struct {
    logic [15:0] ea;
    logic        noea;
    logic        err;
    int          lat;
    int          reqs;
    int          issue;
  } exp_t;

  exp_t sb[$];

  // Responder programming: address expected during IND, which request cycle acks (0 = never).
  logic [15:0] rsp_addr = '0;
  logic [15:0] rsp_data = '0;
  int          rsp_ack_at = 0;
  int          req_cnt = 0;
  logic        prev_done = 1'b0;

  // Reference: LC-3 addressing modes straight from the opcode table.
  function automatic void model(input logic [15:0] i_ir, input logic [15:0] i_pc,
                                input logic [15:0] i_base, output logic [15:0] addr,
                                output bit ind, output bit noea);
    logic [15:0] o6;
    logic [15:0] o9;
    logic [15:0] o11;
    o6  = {{10{i_ir[5]}}, i_ir[5:0]};
    o9  = {{7{i_ir[8]}},  i_ir[8:0]};
    o11 = {{5{i_ir[10]}}, i_ir[10:0]};
    ind  = 0;
    noea = 0;
    addr = 16'h0000;
    case (i_ir[15:12])
      4'd0, 4'd2, 4'd3, 4'd14: addr = 16'((32'(i_pc) + 32'(o9)) % 65536);
      4'd10, 4'd11: begin addr = 16'((32'(i_pc) + 32'(o9)) % 65536); ind = 1; end
      4'd4:  addr = i_ir[11] ? 16'((32'(i_pc) + 32'(o11)) % 65536) : i_base;
      4'd12: addr = i_base;
      4'd6, 4'd7: addr = 16'((32'(i_base) + 32'(o6)) % 65536);
      4'd15: begin addr = 16'(i_ir & 16'h00FF); ind = 1; end
      default: noea = 1;
    endcase
  endfunction

  // Memory responder; also drives spurious acks whenever no request is pending.
  always @(negedge Clk) begin
    if (!busy && start) req_cnt = 0;
    if (mem_req) begin
      req_cnt++;
      chk("mem_addr", mem_addr, rsp_addr);
      if (rsp_ack_at != 0 && req_cnt == rsp_ack_at) begin
        mem_ack   = 1'b1;
        mem_rdata = rsp_data;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 16'($urandom);
      end
    end else begin
      mem_ack   = ($urandom_range(0, 3) == 0);
      mem_rdata = 16'($urandom);
    end
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge Clk) begin
    if (done) begin
      chk("done_single_cycle", {31'b0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ea", ea, e.ea);
        chk("no_ea", no_ea, e.noea);
        chk("err", err, e.err);
        chk("latency", cyc - e.issue, e.lat);
        chk("req_cycles", req_cnt, e.reqs);
      end
    end
    prev_done = done;
  end

  function automatic exp_t make_exp(input logic [15:0] i_ir, input logic [15:0] i_pc,
                                    input logic [15:0] i_base, input int ack_at,
                                    input logic [15:0] rdata, input int issue);
    exp_t        e;
    logic [15:0] addr;
    bit          ind;
    bit          noea;
    model(i_ir, i_pc, i_base, addr, ind, noea);
    e.noea  = noea;
    e.issue = issue;
    if (!ind) begin
      e.ea = addr; e.err = 0; e.lat = 2; e.reqs = 0;
    end else if (ack_at > 0 && ack_at <= ACK_TO) begin
      e.ea = rdata; e.err = 0; e.lat = 2 + ack_at; e.reqs = ack_at;
    end else begin
      e.ea = 16'h0000; e.err = 1; e.lat = 2 + ACK_TO; e.reqs = ACK_TO;
    end
    return e;
  endfunction

  task automatic wait_drain();
    for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge Clk);
    chk("sb_drain", sb.size(), 32'd0);
    sb.delete();
  endtask

  task automatic run_op(input logic [15:0] i_ir, input logic [15:0] i_pc,
                        input logic [15:0] i_base, input int ack_at,
                        input logic [15:0] rdata, input bit glitch);
    exp_t        e;
    logic [15:0] addr;
    bit          ind;
    bit          noea;
    model(i_ir, i_pc, i_base, addr, ind, noea);
    @(negedge Clk);
    ir = i_ir; pc = i_pc; base_r = i_base;
    rsp_addr = addr; rsp_ack_at = ack_at; rsp_data = rdata;
    e = make_exp(i_ir, i_pc, i_base, ack_at, rdata, cyc);
    sb.push_back(e);
    start = 1'b1;
    @(negedge Clk);
    // Inputs change after acceptance and a stray start lands in CALC: neither may matter.
    start = glitch;
    ir = 16'($urandom); pc = 16'($urandom); base_r = 16'($urandom);
    @(negedge Clk);
    start = 1'b0;
    wait_drain();
    repeat (2) @(negedge Clk);
    chk("ea_hold", ea, e.ea);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    chk("rst_ea", ea, 32'd0);
    chk("rst_flags", {no_ea, err, busy, done, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);

    run_op(16'h6A3F, 16'h0000, 16'h3000, 0, 16'h0000, 0);  // LDR offset -1
    run_op(16'h0FFF, 16'hFFFF, 16'h0000, 0, 16'h0000, 0);  // BR wrap
    run_op(16'h4BFF, 16'h3001, 16'h0000, 0, 16'h0000, 0);  // JSR
    run_op(16'h4080, 16'h0000, 16'h1234, 0, 16'h0000, 0);  // JSRR
    run_op(16'hA002, 16'h3001, 16'h0000, 4, 16'h4000, 0);  // LDI, ack 4th cycle
    run_op(16'hF025, 16'h5555, 16'hAAAA, 0, 16'h0000, 0);  // TRAP timeout
    run_op(16'h1261, 16'h3000, 16'h3000, 0, 16'h0000, 1);  // ADD, no EA

    // STI aborted by reset in its second IND cycle.
    @(negedge Clk);
    ir = 16'hB005; pc = 16'h4000; base_r = 16'h0000;
    rsp_addr = 16'h4005; rsp_ack_at = 0;
    start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    chk("abort_req_cycles", req_cnt, 32'd2);
    chk("abort_ea", ea, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    chk("abort_flags", {no_ea, err, busy, done, mem_req}, 32'd0);
    repeat (6) @(negedge Clk);

    // Back-to-back LEA with start held: one result every 3 cycles.
    @(negedge Clk);
    ir = 16'hE1F0; pc = 16'h0100; base_r = 16'h0000;
    for (int n = 0; n < 3; n++) sb.push_back(make_exp(16'hE1F0, 16'h0100, 16'h0000, 0, 16'h0, cyc + 3 * n));
    start = 1'b1;
    repeat (8) @(negedge Clk);
    start = 1'b0;
    wait_drain();

    for (int n = 0; n < 60; n++) begin
      run_op(16'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(0, 6)),
             16'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ea_unit.md
# ea_unit

Effective-address unit for the SLC-3 datapath, sitting directly downstream of the 16-bit sign-extended offsets (offset6, PCoffset9, PCoffset11) and upstream of MAR/PC load. Given a latched IR, the incremented PC and the SR1/BaseR value, it decodes the opcode, forms the LC-3 effective address, and for LDI/STI/TRAP performs the indirect memory read itself over a req/ack handshake. It reports completion with a one-cycle `done` pulse so the control FSM can stall on `busy`.

## Interface
- `ACK_TIMEOUT`, default 16: maximum cycles `mem_req` may stay high without `mem_ack`. 0 disables the timeout.
- `Clk`  in  1  system clock; all state updates on rising edge
- `Reset`  in  1  synchronous, active-high reset
- `start`  in  1  begin a computation; sampled only in IDLE
- `ir`  in  16  instruction register value
- `pc`  in  16  already-incremented PC
- `base_r`  in  16  SR1/BaseR register value
- `sext6`, `sext9`, `sext11`  in  16 each  sign-extended IR[5:0], IR[8:0], IR[10:0]
- `mem_req`  out  1  indirect read request
- `mem_addr`  out  16  indirect read address
- `mem_ack`  in  1  read data valid this cycle
- `mem_rdata`  in  16  read data
- `ea`  out  16  effective address, held until the next `start` is accepted
- `no_ea`  out  1  opcode has no effective address; `ea` = 0
- `err`  out  1  indirect read timed out; `ea` = 0
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE, CALC, IND, DONE.
- IDLE with `start`=1:
  - Latch `ir`, `pc`, `base_r`, `sext6`, `sext9`, `sext11`.
  - Clear `ea`, `no_ea`, `err`.
  - Go to CALC.
- CALC: compute the sum into the `ea` register, with addition mod 2^16 and the carry discarded. Opcode = ir[15:12]:
  - 0000 BR, 0010 LD, 0011 ST, 1110 LEA: pc + sext9 -> DONE.
  - 1010 LDI, 1011 STI: pc + sext9 -> IND.
  - 0100 with ir[11]=1 (JSR): pc + sext11 -> DONE.
  - 0100 with ir[11]=0 (JSRR): base_r -> DONE.
  - 1100 JMP/RET: base_r -> DONE.
  - 0110 LDR, 0111 STR: base_r + sext6 -> DONE.
  - 1111 TRAP: {8'h00, ir[7:0]} (zero-extended, not sign-extended) -> IND.
  - 0001, 0101, 1001, 1000, 1101: `ea`=0, `no_ea`=1 -> DONE.
- IND:
  - `mem_req`=1 and `mem_addr`=`ea` for every cycle in IND.
  - On a cycle with `mem_ack`=1: `ea` <= `mem_rdata`, go to DONE.
  - If `ACK_TIMEOUT`!=0 and the wait counter reaches `ACK_TIMEOUT` cycles without ack: `ea`=0, `err`=1, go to DONE.
  - The counter clears on entry to IND.
- DONE: `done`=1 for exactly one cycle, then IDLE. `ea`, `no_ea` and `err` stay stable until the next accepted `start`.
- `start` asserted outside IDLE is ignored; it is not queued.
- `mem_ack` outside IND is ignored.

## Timing
- Reset values: state IDLE; `ea`=0, `no_ea`=0, `err`=0, `busy`=0, `done`=0, `mem_req`=0, `mem_addr`=0.
- Reset during any state, including mid-IND, returns to IDLE at that edge:
  - `mem_req` is low the following cycle.
  - No `done` pulse is produced for the aborted operation.
- Direct path: `start` sampled at edge k; CALC during cycle k+1; `done`=1 during cycle k+2. Latency is 2 cycles.
- Indirect path:
  - IND entered at edge k+2; `mem_req` is high from cycle k+2.
  - Ack sampled at edge m; `done`=1 during cycle m+1.
  - Minimum latency is 3 cycles, with ack in the first IND cycle.
- Timeout: with `ACK_TIMEOUT`=N, `mem_req` is high for exactly N cycles; `done` is asserted in the cycle after the last request cycle.
- `mem_addr` is stable while `mem_req` is high.
- Back-to-back: `start` held high re-triggers in the IDLE cycle after DONE, so one operation completes per 3 cycles on the direct path.

## Test plan
- LDR: ir=16'h6A3F (offset6=-1), base_r=16'h3000, sext6=16'hFFFF, start pulse -> `done` 2 cycles later, `ea`=16'h2FFF, `no_ea`=0, `err`=0, `mem_req` never high.
- BR wrap-around: ir=16'h0FFF, pc=16'hFFFF, sext9=16'hFFFF -> `ea`=16'hFFFE.
- JSR vs JSRR: ir=16'h4BFF, pc=16'h3001, sext11=16'h03FF gives `ea`=16'h3400. ir=16'h4080, base_r=16'h1234 gives `ea`=16'h1234.
- LDI with ack on the 4th IND cycle:
  - Setup: ir=16'hA002, pc=16'h3001, sext9=16'h0002, `mem_rdata`=16'h4000.
  - Required: `mem_addr`=16'h3003 held for 4 cycles, `ea`=16'h4000, `done` the cycle after ack.
- TRAP timeout with ACK_TIMEOUT=16:
  - Setup: ir=16'hF025, no ack.
  - Required: `mem_addr`=16'h0025, `mem_req` high exactly 16 cycles, `err`=1, `ea`=0, single `done`.
- ADD and reset: ir=16'h1261 gives `no_ea`=1, `ea`=0 after 2 cycles. Separately, Reset asserted in the 2nd IND cycle of an STI gives `mem_req`=0, `busy`=0, all outputs zero next cycle, and no `done`.
